// File: rtl/alu_iter_seq.sv
// Iterative 16-bit multiply / restoring divide built on a shared single-cycle ALU.
// Each RUN cycle issues one ALU op; results land in res_q/res_r on the RUN->DONE edge.
module alu_iter_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] res_q,
    output logic [15:0] res_r,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_lt
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_PASS = 3'b111;

    state_t      state, state_nx;
    logic        op_r;
    logic [3:0]  cnt;
    logic [15:0] acc;   // product accumulator, or partial remainder when dividing
    logic [15:0] m;     // shifted multiplicand, or divisor
    logic [15:0] q;     // multiplier bits, or dividend bits becoming quotient
    logic [15:0] acc_nx, m_nx, q_nx, rem_sh;
    logic        div_err;
    logic        unused_zero;

    assign unused_zero = alu_zero;
    assign div_err     = op && ((opb == 16'd0) || opb[15]);
    assign rem_sh      = {acc[14:0], q[15]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = div_err ? DONE : RUN;
            RUN:     if (cnt == 4'd15) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        alu_ctrl = ALU_PASS;
        alu_a    = 16'd0;
        alu_b    = 16'd0;
        if (state == RUN) begin
            alu_ctrl = op_r ? ALU_SUB : ALU_ADD;
            alu_a    = m;
            alu_b    = op_r ? rem_sh : acc;
        end
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        acc_nx = acc;
        m_nx   = m;
        q_nx   = q;
        if (!op_r) begin
            if (q[0]) acc_nx = alu_result;
            m_nx = m << 1;
            q_nx = q >> 1;
        end else if (!alu_lt) begin
            acc_nx = alu_result;
            q_nx   = {q[14:0], 1'b1};
        end else begin
            acc_nx = rem_sh;
            q_nx   = {q[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r  <= 1'b0;
            cnt   <= 4'd0;
            acc   <= 16'd0;
            m     <= 16'd0;
            q     <= 16'd0;
            err   <= 1'b0;
            res_q <= 16'd0;
            res_r <= 16'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_r <= op;
                    cnt  <= 4'd0;
                    acc  <= 16'd0;
                    if (div_err) begin
                        err   <= 1'b1;
                        res_q <= 16'hFFFF;
                        res_r <= opa;
                    end else begin
                        m <= op ? opb : opa;
                        q <= op ? opa : opb;
                    end
                end
                RUN: begin
                    cnt <= cnt + 4'd1;
                    acc <= acc_nx;
                    m   <= m_nx;
                    q   <= q_nx;
                    if (cnt == 4'd15) begin
                        err   <= 1'b0;
                        res_q <= op_r ? q_nx : acc_nx;
                        res_r <= op_r ? acc_nx : 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_iter_seq.sv
// Bench for alu_iter_seq: behavioural ALU, arithmetic reference model, directed and random ops.
module tb_alu_iter_seq;
    logic        clk = 1'b0;
    logic        rst_n, start, op;
    logic [15:0] opa, opb;
    logic        busy, done, err;
    logic [15:0] res_q, res_r, alu_a, alu_b, alu_result;
    logic [2:0]  alu_ctrl;
    logic        alu_zero, alu_lt;

    int vectors = 0;
    int miscompares = 0;

    alu_iter_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .err(err), .res_q(res_q), .res_r(res_r),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt)
    );

    always #5 clk = ~clk;

    // Shared combinational ALU
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_b - alu_a;
            default: alu_result = alu_a;
        endcase
        alu_zero = (alu_result == 16'd0);
        alu_lt   = alu_result[15];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic o, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] eq, output logic [15:0] er, output logic ee);
        int unsigned p;
        p = a * b;
        ee = 1'b0;
        if (!o) begin
            eq = p[15:0];
            er = 16'd0;
        end else if (b == 16'd0 || b >= 16'h8000) begin
            ee = 1'b1;
            eq = 16'hFFFF;
            er = a;
        end else begin
            eq = a / b;
            er = a % b;
        end
    endfunction

    // Issue one op, follow it to done, check latency, drive, results and hold
    task automatic do_op(input string tag, input logic o, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] eq, er;
        logic        ee;
        int          n;
        model(o, a, b, eq, er, ee);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".ctrl"}, alu_ctrl, ee ? 3'b111 : (o ? 3'b001 : 3'b000));
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".lat"}, n, ee ? 0 : 16);
        chk({tag, ".q"}, res_q, eq);
        chk({tag, ".r"}, res_r, er);
        chk({tag, ".err"}, err, ee);
        @(posedge clk); #1;
        chk({tag, ".idle"}, {busy, done}, 2'b00);
        chk({tag, ".hold"}, res_q, eq);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        ro;
        int          n;
        bit          seen;

        rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = 16'd0; opb = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.outs", {busy, done, err, res_q, res_r}, 35'd0);
        chk("rst.alu", {alu_ctrl, alu_a, alu_b}, {3'b111, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mul300x200", 1'b0, 16'd300, 16'd200);
        do_op("mul_trunc", 1'b0, 16'h1234, 16'h0100);
        do_op("mul_zero", 1'b0, 16'h0000, 16'hFFFF);
        do_op("div1000_7", 1'b1, 16'd1000, 16'd7);
        do_op("div_ffff", 1'b1, 16'hFFFF, 16'h7FFF);
        do_op("div_by0", 1'b1, 16'd5, 16'h0000);
        do_op("div_by8000", 1'b1, 16'd5, 16'h8000);

        // start pulse during RUN must be dropped, not queued
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 16'd300; opb = 16'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 1'b1; opa = 16'd9; opb = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        n = 5;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign.lat", n, 16);
        chk("ign.q", res_q, 16'hEA60);
        chk("ign.r", res_r, 16'd0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy || done) seen = 1'b1;
        end
        chk("ign.noqueue", seen, 1'b0);

        // reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 1'b1; opa = 16'd1000; opb = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.outs", {busy, done, err, res_q, res_r}, 35'd0);
        chk("abort.alu", {alu_ctrl, alu_a, alu_b}, {3'b111, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy || done) seen = 1'b1;
        end
        chk("abort.nodone", seen, 1'b0);
        do_op("post_abort", 1'b1, 16'd1000, 16'd7);

        // start held high: one operation every 18 cycles
        @(negedge clk);
        start = 1'b1; op = 1'b0; opa = 16'd3; opb = 16'd5;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 40);
        chk("b2b.gap", n, 18);
        chk("b2b.q", res_q, 16'd15);
        start = 1'b0;
        n = 0;
        while ((busy || done) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b.drain", busy, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = 16'd0;
                1:       rb = 16'h8000 | 16'($urandom);
                2:       rb = 16'($urandom_range(1, 15));
                default: rb = ro ? (16'($urandom) & 16'h7FFF) : 16'($urandom);
            endcase
            do_op($sformatf("rnd%0d", i), ro, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
